mul_share_arbiter: RTL and testbench
====================================

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the multiplier (2..16).
REQ-002 Parameter INPUT_WIDTH, default 8: width of each operand.
REQ-003 Parameter OUTPUT_WIDTH, default 16: width of the product returned.
REQ-004 clock  input  1: rising-edge clock for all state.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ: per-requester operand-pair valid.
REQ-007 req_ready  output  NUM_REQ: per-requester accept strobe, one-hot or zero.
REQ-008 req_in0  input  NUM_REQ*INPUT_WIDTH: packed first operands; requester k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 req_in1  input  NUM_REQ*INPUT_WIDTH: packed second operands, same packing as req_in0.
REQ-010 rsp_valid  output  NUM_REQ: one-hot result valid, addressed to the owning requester.
REQ-011 rsp_ready  input  NUM_REQ: per-requester result accept.
REQ-012 rsp_data  output  OUTPUT_WIDTH: shared product bus, meaningful only while any rsp_valid bit is high.

Function
REQ-013 The FSM SHALL have states IDLE, MUL and DONE. With MUL_ARB_PIPE_EN defined it SHALL also have state MUL2 between MUL and DONE.
REQ-014 In IDLE with any req_valid high, the block SHALL grant exactly one requester:
- Search is round-robin, starting at index (last_grant+1) mod NUM_REQ.
- The winner's req_ready bit is asserted combinationally in that same cycle.
- Both operands and the winner index are latched.
- The FSM moves to MUL.
REQ-015 A transfer SHALL occur only when req_valid[k] and req_ready[k] are both high. req_ready SHALL be all-zero outside IDLE.
REQ-016 MUL SHALL register product = in0 * in1, computed unsigned at 2*INPUT_WIDTH bits.
- The product is zero-extended to OUTPUT_WIDTH when OUTPUT_WIDTH is wider.
- The product is truncated to its low OUTPUT_WIDTH bits when OUTPUT_WIDTH is narrower.
- The FSM moves to DONE (or to MUL2 when pipelined).
REQ-017 In DONE, rsp_valid[id] SHALL be high and rsp_data SHALL hold the product stably until rsp_ready[id] is high. The FSM then returns to IDLE and last_grant is set to id.
REQ-018 rsp_ready bits of non-owning requesters SHALL be ignored.
REQ-019 Minimum latency SHALL be 2 cycles from accept to rsp_valid, or 3 cycles with MUL_ARB_PIPE_EN. Throughput SHALL be one operation per 3 cycles when rsp_ready is held high, or one per 4 cycles with MUL_ARB_PIPE_EN.
REQ-020 A requester that deasserts req_valid before being granted SHALL lose nothing and SHALL NOT be granted.
REQ-021 If all NUM_REQ requesters are valid continuously, each SHALL be granted once in every NUM_REQ consecutive grants.

Reset
REQ-022 While reset is high:
- The FSM SHALL go to IDLE.
- req_ready, rsp_valid and rsp_data SHALL be 0.
- last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight product without emitting rsp_valid.

Configuration
REQ-024 Macro MUL_ARB_PIPE_EN: when defined, the block SHALL insert a second product register (state MUL2), adding one cycle of latency for timing closure. When undefined, the block SHALL use a single product register. Arbitration and handshake behaviour SHALL be identical in both builds.

Structure
REQ-025 Package mul_arb_pkg SHALL hold:
- the state enum (IDLE, MUL, MUL2, DONE);
- the state encoding width constant;
- the index-width function clog2.
REQ-026 Sub-module mul_arb_rr SHALL be purely combinational. It takes the request vector and last_grant and returns a one-hot grant and its index. The pointer register stays in mul_share_arbiter.

Verification
REQ-027 Single request: req_valid=0001, in0=8'd12, in1=8'd11 -> req_ready=0001 for one cycle; rsp_valid=0001 with rsp_data=16'd132 two cycles later (three with MUL_ARB_PIPE_EN).
REQ-028 Full contention: all 4 requesters valid for 8 grants after reset -> grant order 0,1,2,3,0,1,2,3.
REQ-029 Backpressure: rsp_ready[2]=0 for 5 cycles on a result for requester 2 with in0=8'hFF, in1=8'hFF -> rsp_valid=0100 and rsp_data=16'hFE01 held stable for 5 cycles, and req_ready=0000 during that time.
REQ-030 Truncation: OUTPUT_WIDTH=8, in0=8'd20, in1=8'd20 -> rsp_data=8'h90 (low byte of 400).
REQ-031 Reset mid-operation: reset pulsed during MUL -> no rsp_valid follows; next grant goes to requester 0.
REQ-032 Wrong-owner ack: rsp_ready=1000 while rsp_valid=0001 -> response held; it completes only when rsp_ready[0]=1.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
package mul_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  // Index width for a vector of 'value' entries; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mul_arb_rr.sv
// Combinational round-robin picker: scans the request vector starting one
// past the previous winner and returns a one-hot grant plus its index.
module mul_arb_rr
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic w_found;

  // First requester found after the previous winner, wrapping around.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int cand;
      cand = (int'(i_last_grant) + i) % NUM_REQ;
      if (!w_found && i_req[cand]) begin
        w_found       = 1'b1;
        o_grant[cand] = 1'b1;
        o_grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// One unsigned multiplier shared by NUM_REQ requesters. A requester is
// granted round-robin in IDLE, its operands are multiplied in MUL and the
// product is held in DONE until that requester accepts it.
// Build option: define MUL_ARB_PIPE_EN to add a second product register
// (state MUL2), one extra cycle of latency for timing closure.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in0,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in1,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [OUTPUT_WIDTH-1:0]        rsp_data
);

  localparam int IDX_W  = clog2(NUM_REQ);
  localparam int PROD_W = 2 * INPUT_WIDTH;
  localparam int EXT_W  = (PROD_W > OUTPUT_WIDTH) ? PROD_W : OUTPUT_WIDTH;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  state_t                   r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_last_grant;
  logic [IDX_W-1:0]         r_id;
  logic [NUM_REQ-1:0]       w_grant;
  logic [IDX_W-1:0]         w_grant_idx;
  logic                     w_accept;
  logic                     w_rsp_done;
  logic [INPUT_WIDTH-1:0]   r_in0_p0, r_in1_p0;
  logic [PROD_W-1:0]        w_prod_full;
  logic [OUTPUT_WIDTH-1:0]  r_prod_p1;
  logic [OUTPUT_WIDTH-1:0]  w_prod_out;

  // Zero-extend or truncate the full-width product to the output bus.
  function automatic logic [OUTPUT_WIDTH-1:0] fit_product(input logic [PROD_W-1:0] p);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(p);
    return ext[OUTPUT_WIDTH-1:0];
  endfunction

  mul_arb_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  assign w_accept    = |w_grant;
  assign w_rsp_done  = rsp_ready[r_id];
  assign w_prod_full = PROD_W'(r_in0_p0) * PROD_W'(r_in1_p0);

  // Control state: FSM, round-robin pointer and owner of the operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_INIT;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_accept) r_id <= w_grant_idx;
      if (r_state == DONE && w_rsp_done) r_last_grant <= r_id;
    end
  end

  // Stage p0: capture the winner's operands at the accept cycle.
  always_ff @(posedge clock) begin
    if (r_state == IDLE && w_accept) begin
      r_in0_p0 <= req_in0[w_grant_idx*INPUT_WIDTH +: INPUT_WIDTH];
      r_in1_p0 <= req_in1[w_grant_idx*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

  // Stage p1: register the fitted product.
  always_ff @(posedge clock) begin
    if (r_state == MUL) r_prod_p1 <= fit_product(w_prod_full);
  end

`ifdef MUL_ARB_PIPE_EN
  logic [OUTPUT_WIDTH-1:0] r_prod_p2;

  // Stage p2: extra product register for timing closure.
  always_ff @(posedge clock) begin
    if (r_state == MUL2) r_prod_p2 <= r_prod_p1;
  end

  assign w_prod_out = r_prod_p2;
`else
  assign w_prod_out = r_prod_p1;
`endif

  // Next state and handshake outputs; everything is forced quiet during reset.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_accept) w_state_nxt = MUL;
      end
      MUL: begin
`ifdef MUL_ARB_PIPE_EN
        w_state_nxt = MUL2;
`else
        w_state_nxt = DONE;
`endif
      end
      MUL2: w_state_nxt = DONE;
      DONE: begin
        rsp_valid[r_id] = 1'b1;
        rsp_data        = w_prod_out;
        if (w_rsp_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (reset) begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: a 16-bit-output instance for
// arbitration and handshake scenarios plus an 8-bit-output instance for
// product truncation.
module tb_mul_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int OW = 16;
`ifdef MUL_ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_in0 = '0;
  logic [N*IW-1:0] req_in1 = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [OW-1:0]   rsp_data;

  logic [N-1:0]    t_req_valid = '0;
  logic [N-1:0]    t_req_ready;
  logic [N*IW-1:0] t_in0 = '0;
  logic [N*IW-1:0] t_in1 = '0;
  logic [N-1:0]    t_rsp_valid;
  logic [N-1:0]    t_rsp_ready = '0;
  logic [7:0]      t_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  mul_share_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in0   (req_in0),
    .req_in1   (req_in1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  mul_share_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(8)) u_dut8 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (t_req_valid),
    .req_ready (t_req_ready),
    .req_in0   (t_in0),
    .req_in1   (t_in1),
    .rsp_valid (t_rsp_valid),
    .rsp_ready (t_rsp_ready),
    .rsp_data  (t_rsp_data)
  );

  always #5 clock = ~clock;
  always @(negedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ops(input int k, input int a, input int b);
    req_in0[k*IW +: IW] = IW'(a);
    req_in1[k*IW +: IW] = IW'(b);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    t_req_valid = '1;
    for (int k = 0; k < N; k++) set_ops(k, 255, 255);
    repeat (2) @(negedge clock);
    #1;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end n_checks++;
    if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end n_checks++;
    if (rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end n_checks++;
    if (t_req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready8: got %b expected 0000", t_req_ready); end n_checks++;
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    t_req_valid = '0;
    #1;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL post_reset_idle_ready: got %b expected 0000", req_ready); end n_checks++;
  endtask

  task automatic test_single();
    int  t0;
    bit  got;
    @(negedge clock);
    req_valid = 4'b0001;
    rsp_ready = '1;
    set_ops(0, 12, 11);
    #1;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", req_ready); end n_checks++;
    sb.push_back('{id: 0, data: 16'd132});
    t0 = cyc;
    @(negedge clock);
    req_valid = '0;
    #1;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_busy: got %b expected 0000", req_ready); end n_checks++;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid != 0) begin got = 1; break; end
      @(negedge clock); #1;
    end
    if (!got) begin n_fail++; $display("FAIL single_timeout: rsp_valid %b expected nonzero", rsp_valid); end n_checks++;
    if (cyc - t0 != LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", cyc - t0, LAT); end n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL single_sb_empty: got 0 entries expected 1"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected %b", rsp_valid, 4'(1 << e.id)); end
      if (rsp_data !== e.data) begin n_fail++; $display("FAIL single_rsp_data: got %0d expected %0d", rsp_data, e.data); end
    end
    n_checks += 2;
    @(negedge clock); #1;
    if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_drop: got %b expected 0000", rsp_valid); end n_checks++;
  endtask

  task automatic test_contention();
    int last;
    bit got;
    @(negedge clock);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < N; k++) set_ops(k, k*17 + 3, k*29 + 5);
    req_valid = '1;
    rsp_ready = '1;
    last = 0;
    for (int g = 0; g < 8; g++) begin
      #1;
      got = 0;
      for (int t = 0; t < 10; t++) begin
        if (req_ready != 0) begin got = 1; break; end
        @(negedge clock); #1;
      end
      if (!got) begin n_fail++; $display("FAIL contention_grant_timeout: grant %0d never came", g); end n_checks++;
      if (req_ready !== 4'(1 << (g % N))) begin n_fail++; $display("FAIL contention_order: grant %0d got %b expected %b", g, req_ready, 4'(1 << (g % N))); end n_checks++;
      if (g > 0 && cyc - last != LAT + 1) begin n_fail++; $display("FAIL contention_throughput: got %0d cycles expected %0d", cyc - last, LAT + 1); end
      if (g > 0) n_checks++;
      last = cyc;
      sb.push_back('{id: g % N, data: 16'(((g % N)*17 + 3) * ((g % N)*29 + 5))});
      @(negedge clock); #1;
      got = 0;
      for (int t = 0; t < 10; t++) begin
        if (rsp_valid != 0) begin got = 1; break; end
        @(negedge clock); #1;
      end
      if (!got) begin n_fail++; $display("FAIL contention_rsp_timeout: op %0d no response", g); end n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL contention_sb_empty: got 0 entries expected 1"); end
      else begin
        e = sb.pop_front();
        if (rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL contention_rsp_valid: got %b expected %b", rsp_valid, 4'(1 << e.id)); end
        if (rsp_data !== e.data) begin n_fail++; $display("FAIL contention_rsp_data: got %h expected %h", rsp_data, e.data); end
      end
      n_checks += 2;
      @(negedge clock);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    bit got;
    @(negedge clock);
    set_ops(2, 255, 255);
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    #1;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end n_checks++;
    sb.push_back('{id: 2, data: 16'hFE01});
    @(negedge clock);
    req_valid = 4'b1011;
    #1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid != 0) begin got = 1; break; end
      @(negedge clock); #1;
    end
    if (!got) begin n_fail++; $display("FAIL bp_timeout: rsp_valid %b expected nonzero", rsp_valid); end n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL bp_sb_empty: got 0 entries expected 1"); e = '{id: 2, data: 16'hFE01}; end
    else e = sb.pop_front();
    n_checks++;
    for (int h = 0; h < 5; h++) begin
      if (rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL bp_hold_valid: cycle %0d got %b expected %b", h, rsp_valid, 4'(1 << e.id)); end n_checks++;
      if (rsp_data !== e.data) begin n_fail++; $display("FAIL bp_hold_data: cycle %0d got %h expected %h", h, rsp_data, e.data); end n_checks++;
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_ready: cycle %0d got %b expected 0000", h, req_ready); end n_checks++;
      @(negedge clock);
      if (h == 4) begin
        req_valid = '0;
        rsp_ready = 4'b0100;
      end
      #1;
    end
    if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0100", rsp_valid); end n_checks++;
    @(negedge clock); #1;
    if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_done: got %b expected 0000", rsp_valid); end n_checks++;
  endtask

  task automatic test_wrong_owner();
    bit got;
    @(negedge clock);
    set_ops(0, 7, 9);
    req_valid = 4'b0001;
    rsp_ready = 4'b1000;
    #1;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wo_grant: got %b expected 0001", req_ready); end n_checks++;
    sb.push_back('{id: 0, data: 16'd63});
    @(negedge clock);
    req_valid = '0;
    #1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid != 0) begin got = 1; break; end
      @(negedge clock); #1;
    end
    if (!got) begin n_fail++; $display("FAIL wo_timeout: rsp_valid %b expected nonzero", rsp_valid); end n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL wo_sb_empty: got 0 entries expected 1"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL wo_rsp_valid: got %b expected %b", rsp_valid, 4'(1 << e.id)); end
      if (rsp_data !== e.data) begin n_fail++; $display("FAIL wo_rsp_data: got %0d expected %0d", rsp_data, e.data); end
    end
    n_checks += 2;
    for (int h = 0; h < 3; h++) begin
      @(negedge clock); #1;
      if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL wo_held: cycle %0d got %b expected 0001", h, rsp_valid); end n_checks++;
    end
    @(negedge clock);
    rsp_ready = 4'b0001;
    #1;
    if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL wo_owner_ack_valid: got %b expected 0001", rsp_valid); end n_checks++;
    @(negedge clock); #1;
    if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL wo_done: got %b expected 0000", rsp_valid); end n_checks++;
    rsp_ready = '1;
  endtask

  task automatic test_withdraw();
    bit got;
    @(negedge clock);
    set_ops(2, 3, 4);
    set_ops(1, 5, 6);
    set_ops(3, 8, 8);
    req_valid = 4'b0100;
    rsp_ready = '1;
    #1;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wd_first_grant: got %b expected 0100", req_ready); end n_checks++;
    sb.push_back('{id: 2, data: 16'd12});
    @(negedge clock);
    req_valid = 4'b1000;
    #1;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_busy_ready: got %b expected 0000", req_ready); end n_checks++;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid != 0) begin got = 1; break; end
      @(negedge clock); #1;
    end
    if (!got) begin n_fail++; $display("FAIL wd_timeout: rsp_valid %b expected nonzero", rsp_valid); end n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL wd_sb_empty: got 0 entries expected 1"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL wd_rsp_valid: got %b expected %b", rsp_valid, 4'(1 << e.id)); end
      if (rsp_data !== e.data) begin n_fail++; $display("FAIL wd_rsp_data: got %0d expected %0d", rsp_data, e.data); end
    end
    n_checks += 2;
    req_valid = 4'b0010;
    @(negedge clock); #1;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wd_second_grant: got %b expected 0010", req_ready); end n_checks++;
    sb.push_back('{id: 1, data: 16'd30});
    @(negedge clock);
    req_valid = '0;
    #1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid != 0) begin got = 1; break; end
      @(negedge clock); #1;
    end
    if (!got) begin n_fail++; $display("FAIL wd2_timeout: rsp_valid %b expected nonzero", rsp_valid); end n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL wd2_sb_empty: got 0 entries expected 1"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL wd2_rsp_valid: got %b expected %b", rsp_valid, 4'(1 << e.id)); end
      if (rsp_data !== e.data) begin n_fail++; $display("FAIL wd2_rsp_data: got %0d expected %0d", rsp_data, e.data); end
    end
    n_checks += 2;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit got;
    @(negedge clock);
    set_ops(2, 9, 9);
    req_valid = 4'b0100;
    #1;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_grant: got %b expected 0100", req_ready); end n_checks++;
    @(negedge clock);
    req_valid = '0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    seen = 0;
    for (int t = 0; t < LAT + 3; t++) begin
      if (rsp_valid != 0) seen = 1;
      @(negedge clock); #1;
    end
    if (seen) begin n_fail++; $display("FAIL rm_spurious_rsp: got rsp_valid after reset expected none"); end n_checks++;
    set_ops(0, 6, 7);
    req_valid = '1;
    #1;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_next_grant: got %b expected 0001", req_ready); end n_checks++;
    sb.push_back('{id: 0, data: 16'd42});
    @(negedge clock);
    req_valid = '0;
    #1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      if (rsp_valid != 0) begin got = 1; break; end
      @(negedge clock); #1;
    end
    if (!got) begin n_fail++; $display("FAIL rm_timeout: rsp_valid %b expected nonzero", rsp_valid); end n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL rm_sb_empty: got 0 entries expected 1"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL rm_rsp_valid: got %b expected %b", rsp_valid, 4'(1 << e.id)); end
      if (rsp_data !== e.data) begin n_fail++; $display("FAIL rm_rsp_data: got %0d expected %0d", rsp_data, e.data); end
    end
    n_checks += 2;
  endtask

  task automatic test_truncation();
    bit got;
    int a;
    int b;
    t_rsp_ready = '1;
    for (int op = 0; op < 2; op++) begin
      a = (op == 0) ? 20 : 255;
      b = (op == 0) ? 20 : 255;
      @(negedge clock);
      t_in0[op*IW +: IW] = IW'(a);
      t_in1[op*IW +: IW] = IW'(b);
      t_req_valid = 4'(1 << op);
      #1;
      if (t_req_ready !== 4'(1 << op)) begin n_fail++; $display("FAIL trunc_grant: op %0d got %b expected %b", op, t_req_ready, 4'(1 << op)); end n_checks++;
      sb.push_back('{id: op, data: 16'((a * b) & 8'hFF)});
      @(negedge clock);
      t_req_valid = '0;
      #1;
      got = 0;
      for (int t = 0; t < 10; t++) begin
        if (t_rsp_valid != 0) begin got = 1; break; end
        @(negedge clock); #1;
      end
      if (!got) begin n_fail++; $display("FAIL trunc_timeout: op %0d rsp_valid %b expected nonzero", op, t_rsp_valid); end n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL trunc_sb_empty: got 0 entries expected 1"); end
      else begin
        e = sb.pop_front();
        if (t_rsp_valid !== 4'(1 << e.id)) begin n_fail++; $display("FAIL trunc_rsp_valid: got %b expected %b", t_rsp_valid, 4'(1 << e.id)); end
        if ({8'h00, t_rsp_data} !== e.data) begin n_fail++; $display("FAIL trunc_rsp_data: got %h expected %h", t_rsp_data, e.data); end
      end
      n_checks += 2;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrong_owner();
    test_withdraw();
    test_reset_mid();
    test_truncation();
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end n_checks++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
